// File: rtl/mm_initiator.sv
// ============================================================================
// mm_initiator : Avalon-style MM bus initiator with in-order read responses,
//                outstanding-read tracking and a sticky response timeout.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mm_initiator #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_be,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  input  logic                readdatavalid,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [3:0]          outstanding,
  output logic                timeout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  logic               read_q, write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [BE_W-1:0]    be_q;
  logic [3:0]         outst_q, outst_d;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               timeout_q;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic               accept, rd_done, rdv_ok, tcnt_clr, tcnt_max;

  // A read is refused when it would push the in-flight count past the limit.
  assign cmd_ready = !reset && (state_q == S_IDLE) && !timeout_q &&
                     (cmd_write || (outst_q < 4'(MAX_OUTSTANDING)));
  assign accept    = cmd_valid && cmd_ready;
  assign rd_done   = (state_q == S_ISSUE) && read_q && !waitrequest;
  assign rdv_ok    = readdatavalid && (outst_q != 4'd0);

  always_comb begin
    outst_d = outst_q;
    case ({rd_done, rdv_ok})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  assign tcnt_clr = readdatavalid || (outst_q == 4'd0);
  assign tcnt_max = (tcnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    tcnt_d = tcnt_q;
    if (tcnt_clr)      tcnt_d = '0;
    else if (!tcnt_max) tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      outst_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      timeout_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      outst_q     <= outst_d;
      tcnt_q      <= tcnt_d;
      rsp_valid_q <= rdv_ok;
      if (rdv_ok) rsp_data_q <= readdata;
      if (!tcnt_clr && tcnt_max) timeout_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            be_q    <= cmd_be;
            // Writes wait behind pending reads so they are never reordered.
            if (cmd_write && (outst_q != 4'd0)) begin
              state_q <= S_DRAIN;
            end else begin
              read_q  <= !cmd_write;
              write_q <= cmd_write;
              state_q <= S_ISSUE;
            end
          end
        end
        S_DRAIN: begin
          if (outst_q == 4'd0) begin
            write_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign address     = addr_q;
  assign read        = read_q;
  assign write       = write_q;
  assign writedata   = wdata_q;
  assign byteenable  = be_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign outstanding = outst_q;
  assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: doc/mm_initiator.md
Name: mm_initiator

Overview:
- Memory-mapped bus initiator: the requesting end of the interface that the bus-side monitor/responder logic observes.
- Accepts read/write commands on a valid/ready port and drives pipelined reads and writes onto an Avalon-style MM bus (address, read, write, waitrequest, readdatavalid).
- Returns read data in order on a response port and tracks outstanding reads, with a response timeout.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byteenable width is DATA_W/8.
- MAX_OUTSTANDING, 4, maximum read transactions in flight (1..15).
- TIMEOUT, 1024, cycles without readdatavalid while reads are pending before the timeout flag is raised (≥2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  write data.
- cmd_be  in  DATA_W/8  byte enables.
- address  out  ADDR_W  bus address.
- read  out  1  bus read request.
- write  out  1  bus write request.
- writedata  out  DATA_W  bus write data.
- byteenable  out  DATA_W/8  bus byte enables.
- waitrequest  in  1  responder stall; the request holds while high.
- readdata  in  DATA_W  read return data.
- readdatavalid  in  1  readdata valid this cycle.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_data  out  DATA_W  read data, in issue order.
- outstanding  out  4  reads issued but not yet returned.
- timeout  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset values:
  - read=write=cmd_ready=rsp_valid=timeout=0.
  - outstanding=0, address/writedata/byteenable/rsp_data=0.
  - State goes to IDLE.
  - Reset asserted mid-transaction drops read/write the next edge and discards the outstanding count; late readdatavalid after reset is ignored.
- States:
  - IDLE: cmd_ready=1, except that cmd_ready=0 when a read command would exceed MAX_OUTSTANDING or timeout=1. cmd_ready is combinational from state, outstanding, timeout and cmd_write.
  - On acceptance of a read: register the command and go to ISSUE.
  - On acceptance of a write with outstanding≠0: register the command and go to DRAIN. Writes are never reordered ahead of pending reads.
  - On acceptance of a write with outstanding=0: register the command and go to ISSUE.
  - DRAIN: cmd_ready=0 and no bus request. Go to ISSUE on the cycle after outstanding reaches 0.
  - ISSUE: drive read or write with the registered address, data and byteenable, starting the cycle after acceptance (1-cycle command-to-bus latency).
    - Hold all bus outputs stable while waitrequest=1.
    - The cycle with waitrequest=0 completes the request. Next state is IDLE, with read/write deasserted that cycle.
    - No back-to-back bus requests, so peak issue rate is one per 2 cycles.
- outstanding:
  - +1 on a completed read request; −1 on readdatavalid.
  - Both in the same cycle leaves it unchanged.
  - readdatavalid while outstanding=0 is ignored, and the count saturates at 0.
- Response: rsp_valid/rsp_data are registered one cycle after readdatavalid/readdata. There is no backpressure.
- Timeout:
  - Counter clears on readdatavalid or when outstanding=0.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT−1, set timeout=1. timeout is sticky and blocks new commands.
- Write completion produces no response.

Test Plan:
- Single read, waitrequest=0, readdatavalid 3 cycles later with 0xDEADBEEF → read high exactly 1 cycle; outstanding 0→1→0; rsp_valid pulse with rsp_data=0xDEADBEEF.
- Write addr 0x100, data 0x12345678, be 0xF, waitrequest high 4 cycles → write/address/writedata stable all 5 cycles; cmd_ready low until return to IDLE; no rsp_valid.
- 5 back-to-back reads with MAX_OUTSTANDING=4 and responses withheld → outstanding reaches 4 and cmd_ready=0 on the 5th; first readdatavalid reopens cmd_ready; responses return in order.
- Read pending then write command → write waits in DRAIN until the read's readdatavalid; write asserts 2 cycles after the response arrives.
- Read issued, no readdatavalid, TIMEOUT=16 → timeout=1 after 16 pending cycles; cmd_ready stays 0; reset clears it.
- Reset asserted during ISSUE with waitrequest=1 → read=0 next edge; outstanding=0; later stray readdatavalid produces no rsp_valid.
